// File: rtl/ttt_board_engine.sv
// Tic-tac-toe datapath: board, player, turn timer, move capture, random search
// and win/tie evaluation, driven by one-cycle command strobes from the game FSM.
module ttt_board_engine #(
    parameter logic [31:0] TURN_CYCLES = 32'd500_000_000,
    parameter int          TMR_W       = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        new_game,
    input  logic        time_start,
    input  logic        validate_play,
    input  logic        play_random,
    input  logic        commit,
    input  logic        change_turn,
    input  logic [3:0]  move_sel,
    input  logic        move_confirm,
    output logic        time_out,
    output logic        ready,
    output logic        valid,
    output logic        win,
    output logic        tie,
    output logic        player,
    output logic        busy,
    output logic [3:0]  sel_cell,
    output logic [17:0] board
);

    typedef enum logic [1:0] {IDLE, SEARCH, EVAL} state_t;

    localparam logic [TMR_W-1:0] CNT_LOAD = TMR_W'(TURN_CYCLES - 32'd1);

    state_t           state;
    logic [1:0]       cells [0:8];
    logic [TMR_W-1:0] cnt;
    logic             armed;
    logic [3:0]       rnd;
    logic [3:0]       idx;
    logic [3:0]       probes;
    logic             win_next;
    logic             full;
    logic             accept;

    for (genvar i = 0; i < 9; i++) begin : g_board
        assign board[2*i +: 2] = cells[i];
    end

    function automatic logic line3(input logic [1:0] a, input logic [1:0] b, input logic [1:0] c);
        return (a != 2'b00) && (a == b) && (b == c);
    endfunction

    always_comb begin
        win_next = line3(cells[0], cells[1], cells[2]) | line3(cells[3], cells[4], cells[5]) |
                   line3(cells[6], cells[7], cells[8]) | line3(cells[0], cells[3], cells[6]) |
                   line3(cells[1], cells[4], cells[7]) | line3(cells[2], cells[5], cells[8]) |
                   line3(cells[0], cells[4], cells[8]) | line3(cells[2], cells[4], cells[6]);
        full = 1'b1;
        for (int i = 0; i < 9; i++)
            if (cells[i] == 2'b00) full = 1'b0;
    end

    assign accept = move_confirm && armed && !time_out && !busy && (move_sel <= 4'd8);

    // Free-running 0..8 counter used as the random-play seed; only rst clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)               rnd <= 4'd0;
        else if (rnd == 4'd8)  rnd <= 4'd0;
        else                   rnd <= rnd + 4'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            for (int i = 0; i < 9; i++) cells[i] <= 2'b00;
            player   <= 1'b0;
            sel_cell <= 4'd0;
            time_out <= 1'b0;
            ready    <= 1'b0;
            valid    <= 1'b0;
            win      <= 1'b0;
            tie      <= 1'b0;
            busy     <= 1'b0;
            armed    <= 1'b0;
            cnt      <= '0;
            idx      <= 4'd0;
            probes   <= 4'd0;
        end else if (new_game) begin
            state    <= IDLE;
            for (int i = 0; i < 9; i++) cells[i] <= 2'b00;
            player   <= 1'b0;
            sel_cell <= 4'd0;
            time_out <= 1'b0;
            ready    <= 1'b0;
            valid    <= 1'b0;
            win      <= 1'b0;
            tie      <= 1'b0;
            busy     <= 1'b0;
            armed    <= 1'b0;
            cnt      <= '0;
            idx      <= 4'd0;
            probes   <= 4'd0;
        end else begin
            if (time_start) begin
                cnt      <= CNT_LOAD;
                armed    <= 1'b1;
                time_out <= 1'b0;
                ready    <= 1'b0;
                valid    <= 1'b0;
            end else if (armed) begin
                // A confirm landing on the expiry cycle still counts as in time.
                if (accept)              armed <= 1'b0;
                else if (cnt == '0) begin
                    time_out <= 1'b1;
                    armed    <= 1'b0;
                end else                 cnt <= cnt - 1'b1;
            end

            if (accept && !time_start) begin
                sel_cell <= move_sel;
                ready    <= 1'b1;
            end

            if (change_turn) player <= ~player;

            unique case (state)
                IDLE: begin
                    if (!time_start) begin
                        if (play_random) begin
                            idx    <= rnd;
                            probes <= 4'd0;
                            state  <= SEARCH;
                            busy   <= 1'b1;
                        end else if (validate_play) begin
                            valid <= (cells[sel_cell] == 2'b00);
                            ready <= 1'b0;
                        end else if (commit && valid && !win && !tie) begin
                            cells[sel_cell] <= player ? 2'b10 : 2'b01;
                            valid <= 1'b0;
                            state <= EVAL;
                            busy  <= 1'b1;
                        end
                    end
                end
                SEARCH: begin
                    if (cells[idx] == 2'b00) begin
                        sel_cell <= idx;
                        valid    <= 1'b1;
                        state    <= IDLE;
                        busy     <= 1'b0;
                    end else if (probes == 4'd8) begin
                        valid <= 1'b0;
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        idx    <= (idx == 4'd8) ? 4'd0 : idx + 4'd1;
                        probes <= probes + 4'd1;
                    end
                end
                EVAL: begin
                    win   <= win_next;
                    tie   <= full & ~win_next;
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ttt_board_engine.sv
// Scoreboard bench for ttt_board_engine: driver tasks predict outcomes from a
// board-level model and queue them; a negedge monitor compares at the due edge.
module tb_ttt_board_engine;

    localparam int TURN = 8;
    localparam int K_TO = 0, K_RDY = 1, K_VLD = 2, K_WIN = 3, K_TIE = 4,
                   K_PLY = 5, K_BSY = 6, K_SEL = 7, K_BRD = 8;

    logic        clk, rst, new_game, time_start, validate_play, play_random;
    logic        commit, change_turn, move_confirm;
    logic [3:0]  move_sel;
    logic        time_out, ready, valid, win, tie, player, busy;
    logic [3:0]  sel_cell;
    logic [17:0] board;

    ttt_board_engine #(.TURN_CYCLES(32'd8), .TMR_W(8)) dut (
        .clk(clk), .rst(rst), .new_game(new_game), .time_start(time_start),
        .validate_play(validate_play), .play_random(play_random), .commit(commit),
        .change_turn(change_turn), .move_sel(move_sel), .move_confirm(move_confirm),
        .time_out(time_out), .ready(ready), .valid(valid), .win(win), .tie(tie),
        .player(player), .busy(busy), .sel_cell(sel_cell), .board(board)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { int at; int kind; int val; string nm; } chk_t;
    chk_t q[$];
    int checks = 0, errors = 0, edges = 0;
    int brnd;

    int m_cells[9];
    int m_player, m_sel, m_valid, m_ready, m_win, m_tie, m_armed, m_deadline;

    always @(posedge clk) edges <= edges + 1;

    always @(posedge clk or posedge rst)
        if (rst) brnd <= 0;
        else     brnd <= (brnd + 1) % 9;

    function automatic int get_out(int k);
        case (k)
            K_TO:  return int'(time_out);
            K_RDY: return int'(ready);
            K_VLD: return int'(valid);
            K_WIN: return int'(win);
            K_TIE: return int'(tie);
            K_PLY: return int'(player);
            K_BSY: return int'(busy);
            K_SEL: return int'(sel_cell);
            default: return int'(board);
        endcase
    endfunction

    always @(negedge clk) begin
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].at == edges) begin
                checks++;
                if (get_out(q[i].kind) !== q[i].val) begin
                    errors++;
                    $display("FAIL %s @edge %0d: got %0d expected %0d",
                             q[i].nm, edges, get_out(q[i].kind), q[i].val);
                end
                q.delete(i);
            end else if (q[i].at < edges) begin
                errors++;
                $display("FAIL %s: check for edge %0d never sampled", q[i].nm, q[i].at);
                q.delete(i);
            end
        end
    end

    task automatic push(int at, int kind, int val, string nm);
        chk_t c;
        c.at = at; c.kind = kind; c.val = val; c.nm = nm;
        q.push_back(c);
    endtask

    task automatic step();
        @(posedge clk); #1;
        new_game = 0; time_start = 0; validate_play = 0; play_random = 0;
        commit = 0; change_turn = 0; move_confirm = 0;
    endtask

    function automatic int m_board();
        int b = 0;
        for (int i = 0; i < 9; i++) b |= m_cells[i] << (2 * i);
        return b;
    endfunction

    function automatic int same3(int a, int b, int c);
        return (m_cells[a] != 0 && m_cells[a] == m_cells[b] && m_cells[b] == m_cells[c]) ? 1 : 0;
    endfunction

    function automatic int m_has_win();
        int w = 0;
        for (int r = 0; r < 3; r++) w |= same3(3*r, 3*r + 1, 3*r + 2);
        for (int c = 0; c < 3; c++) w |= same3(c, c + 3, c + 6);
        w |= same3(0, 4, 8) | same3(2, 4, 6);
        return w;
    endfunction

    function automatic int m_full();
        for (int i = 0; i < 9; i++) if (m_cells[i] == 0) return 0;
        return 1;
    endfunction

    task automatic expect_reset(int at, string nm);
        for (int k = K_TO; k <= K_BRD; k++) push(at, k, 0, nm);
    endtask

    task automatic do_new_game();
        new_game = 1;
        for (int i = 0; i < 9; i++) m_cells[i] = 0;
        m_player = 0; m_sel = 0; m_valid = 0; m_ready = 0; m_win = 0; m_tie = 0; m_armed = 0;
        expect_reset(edges + 1, "new_game");
        step();
    endtask

    task automatic do_time_start();
        int e = edges + 1;
        time_start = 1;
        m_armed = 1; m_deadline = e + TURN; m_ready = 0; m_valid = 0;
        push(e, K_TO, 0, "ts_time_out"); push(e, K_RDY, 0, "ts_ready"); push(e, K_VLD, 0, "ts_valid");
        step();
    endtask

    task automatic do_confirm(int s);
        int e = edges + 1;
        move_sel = 4'(s); move_confirm = 1;
        if (s <= 8 && m_armed != 0 && e < m_deadline) begin
            m_sel = s; m_ready = 1; m_armed = 0;
            push(e, K_SEL, m_sel, "confirm_sel");
        end
        push(e, K_RDY, m_ready, "confirm_ready");
        step();
    endtask

    task automatic do_validate();
        int e = edges + 1;
        validate_play = 1;
        m_valid = (m_cells[m_sel] == 0) ? 1 : 0; m_ready = 0;
        push(e, K_VLD, m_valid, "validate_valid"); push(e, K_RDY, 0, "validate_ready");
        step();
    endtask

    task automatic do_commit();
        int e = edges + 1;
        commit = 1;
        if (m_valid != 0 && m_win == 0 && m_tie == 0) begin
            m_cells[m_sel] = (m_player != 0) ? 2 : 1; m_valid = 0;
            m_win = m_has_win(); m_tie = (m_full() != 0 && m_win == 0) ? 1 : 0;
            push(e, K_BRD, m_board(), "commit_board"); push(e, K_VLD, 0, "commit_valid");
            push(e, K_BSY, 1, "eval_busy"); push(e + 1, K_BSY, 0, "eval_done");
            push(e + 2, K_WIN, m_win, "win"); push(e + 2, K_TIE, m_tie, "tie");
            step(); step(); step();
        end else begin
            push(e, K_BRD, m_board(), "commit_ignored_board"); push(e, K_BSY, 0, "commit_ignored_busy");
            step();
        end
    endtask

    task automatic do_change_turn();
        change_turn = 1; m_player ^= 1;
        push(edges + 1, K_PLY, m_player, "player");
        step();
    endtask

    // abort>0: leave the search running for that many cycles, caller follows with new_game
    task automatic do_random(int force_r, int abort);
        int e, r, k, found;
        if (force_r >= 0)
            for (int w = 0; w < 9 && brnd != force_r; w++) step();
        r = brnd; e = edges + 1; play_random = 1;
        found = -1; k = 9;
        for (int p = 0; p < 9; p++)
            if (m_cells[(r + p) % 9] == 0) begin found = (r + p) % 9; k = p + 1; break; end
        push(e, K_BSY, 1, "search_busy");
        if (abort > 0) begin
            repeat (abort) step();
            return;
        end
        push(e + k - 1, K_BSY, 1, "search_busy_last"); push(e + k, K_BSY, 0, "search_done");
        if (found >= 0) begin m_sel = found; m_valid = 1; end
        else m_valid = 0;
        push(e + k, K_VLD, m_valid, "search_valid"); push(e + k, K_SEL, m_sel, "search_sel");
        repeat (k + 1) step();
    endtask

    task automatic place(int c);
        do_time_start(); do_confirm(c); do_validate(); do_commit(); do_change_turn();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int s, moves;
        rst = 1; new_game = 0; time_start = 0; validate_play = 0; play_random = 0;
        commit = 0; change_turn = 0; move_confirm = 0; move_sel = 0;
        for (int i = 0; i < 9; i++) m_cells[i] = 0;
        m_player = 0; m_sel = 0; m_valid = 0; m_ready = 0; m_win = 0; m_tie = 0; m_armed = 0; m_deadline = 0;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        expect_reset(edges + 1, "reset");
        step();

        // turn timer expiry, one cycle early must still be clear
        do_time_start();
        s = edges;
        push(s + TURN - 1, K_TO, 0, "time_out_early");
        push(s + TURN, K_TO, 1, "time_out");
        push(s + TURN, K_RDY, 0, "time_out_ready");
        repeat (TURN + 1) step();

        place(4);
        do_time_start(); do_confirm(4); do_validate(); do_commit();
        do_time_start(); do_confirm(9);

        do_new_game();
        place(0); place(3); place(1); place(4); place(2);
        do_time_start(); do_confirm(5); do_validate(); do_commit();

        // drawn board: random search from rnd=3 finds cell 8 last
        do_new_game();
        place(0); place(1); place(2); place(4); place(3); place(5); place(7); place(6);
        do_random(3, 0);
        push(edges, K_SEL, 8, "search_sel_cell8");
        do_commit(); do_change_turn();
        do_random(-1, 0);
        do_random(-1, 2);
        do_new_game();

        for (int g = 0; g < 6; g++) begin
            do_new_game();
            moves = 0;
            while (m_win == 0 && m_tie == 0 && moves < 14) begin
                do_time_start();
                if ($urandom_range(1) != 0) begin
                    do_confirm(int'($urandom_range(10)));
                    do_validate();
                end else begin
                    do_random(-1, 0);
                end
                do_commit();
                do_change_turn();
                moves++;
            end
        end

        repeat (3) step();
        foreach (q[i]) begin
            errors++;
            $display("FAIL %s: pending check for edge %0d", q[i].nm, q[i].at);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
